// File: rtl/axi_clint_slave_if.sv
// AXI4 single-beat bus bundle between the LSU data port and the CLINT.
// Master drives requests; slave drives readies and responses.
interface axi_clint_slave_if #(
  parameter int unsigned ID_W = 4
);
  logic [31:0]   s_araddr;
  logic [ID_W-1:0] s_arid;
  logic          s_arvalid;
  logic          s_arready;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic [ID_W-1:0] s_rid;
  logic          s_rlast;
  logic          s_rvalid;
  logic          s_rready;
  logic [31:0]   s_awaddr;
  logic [ID_W-1:0] s_awid;
  logic          s_awvalid;
  logic          s_awready;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_wvalid;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic [ID_W-1:0] s_bid;
  logic          s_bvalid;
  logic          s_bready;

  modport master (
    output s_araddr, s_arid, s_arvalid, s_rready,
    output s_awaddr, s_awid, s_awvalid,
    output s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_arready, s_rdata, s_rresp, s_rid,
    input  s_rlast, s_rvalid, s_awready, s_wready,
    input  s_bresp, s_bid, s_bvalid
  );

  modport slave (
    input  s_araddr, s_arid, s_arvalid, s_rready,
    input  s_awaddr, s_awid, s_awvalid,
    input  s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_arready, s_rdata, s_rresp, s_rid,
    output s_rlast, s_rvalid, s_awready, s_wready,
    output s_bresp, s_bid, s_bvalid
  );
endinterface

// File: rtl/axi_clint_slave.sv
// Core-local timer (mtime/mtimecmp) behind an AXI4 single-beat slave.
// Raises timer_irq one cycle after mtime >= mtimecmp holds.
module axi_clint_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned ID_W      = 4
) (
  input  logic clock,
  input  logic reset,
  axi_clint_slave_if.slave bus,
  output logic timer_irq
);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  rstate_t         rstate_q;
  logic            arready_q;
  logic            rvalid_q;
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q;
  logic [ID_W-1:0] rid_q;

  logic            awready_q;
  logic            wready_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic [ID_W-1:0] bid_q;
  logic [29:0]     awaddr_q;
  logic [ID_W-1:0] awid_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;

  logic [15:0]     div_q, div_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic            irq_q;

  logic            ar_hs, aw_hs, w_hs;
  logic            aw_eff, w_eff, commit, tick;
  logic [5:0]      r_dec, w_dec;
  logic [31:0]     r_data;
  logic [29:0]     w_addr;
  logic [ID_W-1:0] w_id;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic            unused_ok;

  // {resp, one-hot select: mtime_hi, mtime_lo, cmp_hi, cmp_lo}
  function automatic logic [5:0] decode(input logic [29:0] wa);
    logic [5:0] d;
    d = {DECERR, 4'b0000};
    if (wa[29:14] == BASE_ADDR[31:16]) begin
      unique case (1'b1)
        (wa[13:0] == 14'h1000): d = {OKAY, 4'b0001};
        (wa[13:0] == 14'h1001): d = {OKAY, 4'b0010};
        (wa[13:0] == 14'h2FFE): d = {OKAY, 4'b0100};
        (wa[13:0] == 14'h2FFF): d = {OKAY, 4'b1000};
        default:                d = {SLVERR, 4'b0000};
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nd,
    input logic [3:0]  st
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (st[i]) r[8*i +: 8] = nd[8*i +: 8];
    return r;
  endfunction

  assign ar_hs  = bus.s_arvalid & arready_q;
  assign aw_hs  = bus.s_awvalid & awready_q;
  assign w_hs   = bus.s_wvalid & wready_q;
  assign aw_eff = aw_hs | (~awready_q & ~bvalid_q);
  assign w_eff  = w_hs | (~wready_q & ~bvalid_q);
  assign commit = aw_eff & w_eff;

  assign w_addr = aw_hs ? bus.s_awaddr[31:2] : awaddr_q;
  assign w_id   = aw_hs ? bus.s_awid : awid_q;
  assign w_data = w_hs ? bus.s_wdata : wdata_q;
  assign w_strb = w_hs ? bus.s_wstrb : wstrb_q;
  assign r_dec  = decode(bus.s_araddr[31:2]);
  assign w_dec  = decode(w_addr);

  assign unused_ok = ^{bus.s_araddr[1:0], bus.s_awaddr[1:0]};

  // Read mux over the current (pre-write) register values
  always_comb begin
    r_data = '0;
    unique case (1'b1)
      r_dec[0]: r_data = mtimecmp_q[31:0];
      r_dec[1]: r_data = mtimecmp_q[63:32];
      r_dec[2]: r_data = mtime_q[31:0];
      r_dec[3]: r_data = mtime_q[63:32];
      default:  r_data = '0;
    endcase
  end

  // Timer next state: a committed mtime write overrides the tick
  always_comb begin
    tick       = (div_q == 16'(TICK_DIV - 1));
    div_d      = tick ? 16'd0 : div_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (commit) begin
      unique case (1'b1)
        w_dec[0]: mtimecmp_d[31:0] =
          merge(mtimecmp_q[31:0], w_data, w_strb);
        w_dec[1]: mtimecmp_d[63:32] =
          merge(mtimecmp_q[63:32], w_data, w_strb);
        w_dec[2]: mtime_d = {mtime_q[63:32],
          merge(mtime_q[31:0], w_data, w_strb)};
        w_dec[3]: mtime_d = {
          merge(mtime_q[63:32], w_data, w_strb), mtime_q[31:0]};
        default: ;
      endcase
    end
  end

  // Timer registers and registered compare
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q      <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  // Read FSM: one beat in flight, response held until rready
  always_ff @(posedge clock) begin
    if (reset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
    end else begin
      unique case (rstate_q)
        R_IDLE: if (ar_hs) begin
          rdata_q   <= r_data;
          rresp_q   <= r_dec[5:4];
          rid_q     <= bus.s_arid;
          rvalid_q  <= 1'b1;
          arready_q <= 1'b0;
          rstate_q  <= R_RESP;
        end
        R_RESP: if (bus.s_rready) begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
          rstate_q  <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // Write channel: AW and W latch independently, B on commit
  always_ff @(posedge clock) begin
    if (reset) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
      awaddr_q  <= '0;
      awid_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_hs) begin
        awaddr_q  <= bus.s_awaddr[31:2];
        awid_q    <= bus.s_awid;
        awready_q <= 1'b0;
      end
      if (w_hs) begin
        wdata_q  <= bus.s_wdata;
        wstrb_q  <= bus.s_wstrb;
        wready_q <= 1'b0;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_dec[5:4];
        bid_q    <= w_id;
      end
      if (bvalid_q && bus.s_bready) begin
        bvalid_q  <= 1'b0;
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
      end
    end
  end

  assign bus.s_arready = arready_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rdata   = rdata_q;
  assign bus.s_rresp   = rresp_q;
  assign bus.s_rid     = rid_q;
  assign bus.s_rlast   = rvalid_q;
  assign bus.s_awready = awready_q;
  assign bus.s_wready  = wready_q;
  assign bus.s_bvalid  = bvalid_q;
  assign bus.s_bresp   = bresp_q;
  assign bus.s_bid     = bid_q;
  assign timer_irq     = irq_q;
endmodule

// File: tb/tb_axi_clint_slave.sv
// Bench for axi_clint_slave: random AXI traffic against a
// transaction-level CLINT model with a queued scoreboard.
module tb_axi_clint_slave;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic timer_irq;

  axi_clint_slave_if #(.ID_W(4)) bus ();

  axi_clint_slave #(
    .BASE_ADDR(32'h0200_0000),
    .TICK_DIV(1),
    .ID_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .timer_irq(timer_irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [37:0] rq[$];
  logic [5:0]  bq[$];

  logic [63:0] m_mtime, m_cmp;
  logic        m_irq;
  logic        m_aw_have, m_w_have;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_awid, m_wstrb;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tfail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] offs(input logic [31:0] a);
    return {a[15:2], 2'b00};
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a);
    if (a[31:16] != 16'h0200) return 2'b11;
    case (offs(a))
      16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC: return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    if (m_resp(a) != 2'b00) return 32'd0;
    case (offs(a))
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[31:0];
      default:  return m_mtime[63:32];
    endcase
  endfunction

  function automatic logic [31:0] bytes(input logic [31:0] old,
    input logic [31:0] nd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (st[i]) r[8*i +: 8] = nd[8*i +: 8];
    return r;
  endfunction

  // Reference CLINT: mtime counts every cycle unless written
  always @(posedge clock) begin : model
    logic irq_n;
    logic bump;
    if (reset) begin
      m_mtime = '0;
      m_cmp = '1;
      m_irq = 1'b0;
      m_aw_have = 1'b0;
      m_w_have = 1'b0;
      rq.delete();
      bq.delete();
    end else begin
      irq_n = (m_mtime >= m_cmp);
      bump = 1'b1;
      if (bus.s_arvalid && bus.s_arready)
        rq.push_back({m_rdata(bus.s_araddr),
                      m_resp(bus.s_araddr), bus.s_arid});
      if (bus.s_awvalid && bus.s_awready) begin
        m_aw_have = 1'b1;
        m_awaddr = bus.s_awaddr;
        m_awid = bus.s_awid;
      end
      if (bus.s_wvalid && bus.s_wready) begin
        m_w_have = 1'b1;
        m_wdata = bus.s_wdata;
        m_wstrb = bus.s_wstrb;
      end
      if (m_aw_have && m_w_have) begin
        bq.push_back({m_resp(m_awaddr), m_awid});
        if (m_resp(m_awaddr) == 2'b00) begin
          case (offs(m_awaddr))
            16'h4000: m_cmp[31:0] =
              bytes(m_cmp[31:0], m_wdata, m_wstrb);
            16'h4004: m_cmp[63:32] =
              bytes(m_cmp[63:32], m_wdata, m_wstrb);
            16'hBFF8: begin
              m_mtime[31:0] = bytes(m_mtime[31:0], m_wdata, m_wstrb);
              bump = 1'b0;
            end
            default: begin
              m_mtime[63:32] = bytes(m_mtime[63:32], m_wdata, m_wstrb);
              bump = 1'b0;
            end
          endcase
        end
        m_aw_have = 1'b0;
        m_w_have = 1'b0;
      end
      if (bump) m_mtime = m_mtime + 64'd1;
      m_irq = irq_n;
    end
  end

  // Monitor: irq every cycle, pop on each R/B handshake
  always @(negedge clock) begin
    if (!reset && chk_en) begin
      chk("irq", timer_irq, m_irq);
      if (bus.s_rvalid && bus.s_rready) begin
        if (rq.size() == 0) tfail("r_unexpected");
        else begin
          chk("r_beat", {bus.s_rdata, bus.s_rresp, bus.s_rid},
              rq.pop_front());
          chk("r_last", bus.s_rlast, 1'b1);
        end
      end
      if (bus.s_bvalid && bus.s_bready) begin
        if (bq.size() == 0) tfail("b_unexpected");
        else chk("b_beat", {bus.s_bresp, bus.s_bid}, bq.pop_front());
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input logic [3:0] id,
                         input int hold);
    int n;
    logic [31:0] d0;
    logic [3:0] i0;
    n = 0;
    while (!bus.s_arready && n < 20) begin tick(); n++; end
    if (n == 20) begin tfail("ar_wait"); return; end
    bus.s_araddr = a;
    bus.s_arid = id;
    bus.s_arvalid = 1'b1;
    tick();
    bus.s_arvalid = 1'b0;
    chk("r_latency", bus.s_rvalid, 1'b1);
    chk("ar_drop", bus.s_arready, 1'b0);
    d0 = bus.s_rdata;
    i0 = bus.s_rid;
    repeat (hold) begin
      tick();
      chk("r_hold_v", bus.s_rvalid, 1'b1);
      chk("r_hold_d", bus.s_rdata, d0);
      chk("r_hold_id", bus.s_rid, i0);
      chk("r_hold_ar", bus.s_arready, 1'b0);
    end
    bus.s_rready = 1'b1;
    tick();
    bus.s_rready = 1'b0;
    chk("ar_back", bus.s_arready, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
    input logic [3:0] st, input logic [3:0] id,
    input int lead, input int hold);
    int n;
    n = 0;
    while (!(bus.s_awready && bus.s_wready) && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin tfail("aw_w_wait"); return; end
    if (lead >= 0) begin
      bus.s_wdata = d; bus.s_wstrb = st; bus.s_wvalid = 1'b1;
      if (lead > 0) begin
        tick();
        bus.s_wvalid = 1'b0;
        repeat (lead - 1) tick();
      end
      bus.s_awaddr = a; bus.s_awid = id; bus.s_awvalid = 1'b1;
      tick();
    end else begin
      bus.s_awaddr = a; bus.s_awid = id; bus.s_awvalid = 1'b1;
      tick();
      bus.s_awvalid = 1'b0;
      repeat (-lead - 1) tick();
      bus.s_wdata = d; bus.s_wstrb = st; bus.s_wvalid = 1'b1;
      tick();
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid = 1'b0;
    chk("b_latency", bus.s_bvalid, 1'b1);
    repeat (hold) begin
      tick();
      chk("b_hold", bus.s_bvalid, 1'b1);
      chk("aw_hold", bus.s_awready, 1'b0);
    end
    bus.s_bready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    chk("aw_w_back", {bus.s_awready, bus.s_wready}, 2'b11);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 6))
      0: a = 32'h0200_4000;
      1: a = 32'h0200_4004;
      2: a = 32'h0200_BFF8;
      3: a = 32'h0200_BFFC;
      4: a = 32'h0200_0000 | $urandom_range(0, 32'h3FFF);
      5: a = 32'h1000_0000 | $urandom_range(0, 32'hFFFF);
      default: a = 32'h0200_C000 | $urandom_range(0, 32'h3FFF);
    endcase
    return a | 32'($urandom_range(0, 3));
  endfunction

  logic [31:0] ra, wa, wd;
  logic [3:0]  ws;
  int op, lead, hold;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    bus.s_araddr = '0; bus.s_arid = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    bus.s_awaddr = '0; bus.s_awid = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    repeat (3) tick();
    chk("rst_ready", {bus.s_arready, bus.s_awready, bus.s_wready},
        3'b111);
    chk("rst_valid", {bus.s_rvalid, bus.s_bvalid}, 2'b00);
    chk("rst_r", {bus.s_rdata, bus.s_rresp, bus.s_rid}, 38'd0);
    chk("rst_b", {bus.s_bresp, bus.s_bid}, 6'd0);
    chk("rst_irq", timer_irq, 1'b0);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (8) tick();
    do_read(32'h0200_BFF8, 4'h1, 0);
    do_read(32'h0200_4004, 4'h2, 0);
    chk("irq_idle", timer_irq, 1'b0);
    do_write(32'h0200_4000, 32'd50, 4'hF, 4'h3, 0, 0);
    do_write(32'h0200_4004, 32'd0, 4'hF, 4'h3, 0, 1);
    repeat (40) tick();
    do_read(32'h0200_4000, 4'h4, 0);
    do_write(32'h0200_BFFC, 32'd0, 4'hF, 4'h5, -1, 0);
    do_write(32'h0200_BFF8, 32'h1234, 4'hF, 4'h5, 0, 0);
    do_write(32'h0200_BFF8, 32'h0000_AB00, 4'b0010, 4'h6, 3, 0);
    do_read(32'h0200_BFF8, 4'h6, 0);
    do_read(32'h0200_BFFC, 4'h6, 1);
    do_read(32'h0200_0000, 4'h8, 0);
    do_read(32'h1000_0000, 4'h9, 0);
    do_write(32'h0200_0010, 32'hDEAD_BEEF, 4'hF, 4'hA, -2, 0);
    do_write(32'h0200_4000, 32'hFFFF_FFFF, 4'b0000, 4'hB, 1, 0);
    do_read(32'h0200_4000, 4'hC, 0);
    do_read(32'h0200_BFF8, 4'h7, 5);
    fork
      do_read(32'h0200_BFF8, 4'hD, 1);
      do_write(32'h0200_BFF8, 32'h0000_0100, 4'hF, 4'hE, 0, 0);
    join
    do_read(32'h0200_BFF8, 4'hD, 0);
    bus.s_awaddr = 32'h0200_4004;
    bus.s_awid = 4'h2;
    bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    chk("aw_taken", bus.s_awready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", {bus.s_awready, bus.s_wready}, 2'b11);
    chk("mid_rst_b", bus.s_bvalid, 1'b0);
    do_write(32'h0200_4000, 32'd123, 4'hF, 4'h9, 0, 0);
    do_read(32'h0200_4004, 4'h1, 0);
    do_read(32'h0200_4000, 4'h2, 0);
    for (int it = 0; it < 80; it++) begin
      ra = pick_addr();
      wa = pick_addr();
      wd = $urandom();
      ws = 4'($urandom_range(0, 15));
      op = int'($urandom_range(0, 2));
      lead = int'($urandom_range(0, 4)) - 2;
      hold = int'($urandom_range(0, 3));
      if (op == 0) do_read(ra, 4'(it), hold);
      else if (op == 1) do_write(wa, wd, ws, 4'(it), lead, hold);
      else begin
        fork
          do_read(ra, 4'(it), hold);
          do_write(wa, wd, ws, 4'(it + 1), lead, hold);
        join
      end
    end
    repeat (3) tick();
    chk("r_drained", rq.size(), 0);
    chk("b_drained", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_clint_slave.md
Name: axi_clint_slave

Overview:
- Memory-mapped core-local timer (CLINT) that sits on the data-side AXI bus directly downstream of the LSU.
- It serves LSU loads and stores to `mtime`/`mtimecmp` as an AXI4 single-beat slave.
- It raises `timer_irq` toward the CSR/trap logic when `mtime >= mtimecmp`.
- Only single-beat transfers are used: LEN=0, INCR/FIXED ignored. Every read returns the full aligned 32-bit word; the master performs byte-lane shifting.

Parameters:
BASE_ADDR  32'h0200_0000  base of the 64 KiB window; `addr[31:16]` is compared against `BASE_ADDR[31:16]`
TICK_DIV  1  `mtime` increments once every TICK_DIV clock cycles; legal range 1..65535
ID_W  4  AXI ID width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
s_araddr  in  32  read address
s_arid  in  ID_W  read ID
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rid  out  ID_W  read ID echo
s_rlast  out  1  always 1 while `s_rvalid` is high
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_awaddr  in  32  write address
s_awid  in  ID_W  write ID
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bid  out  ID_W  write ID echo
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
timer_irq  out  1  registered `mtime >= mtimecmp`

Behaviour:
- Register map (offset = `addr[15:0]`, word-aligned, `addr[1:0]` ignored):
  - 0x4000 `mtimecmp[31:0]`
  - 0x4004 `mtimecmp[63:32]`
  - 0xBFF8 `mtime[31:0]`
  - 0xBFFC `mtime[63:32]`
- Response codes:
  - OKAY (00) for a mapped offset.
  - SLVERR (10) for an unmapped offset inside the window.
  - DECERR (11) when `addr[31:16]` != `BASE_ADDR[31:16]`.
  - For an error read, `rdata` = 0. For an error write, no register changes.
- Reset values:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `timer_irq` = 0, tick divider = 0.
  - `arready`, `awready`, `wready` = 1.
  - `rvalid`, `bvalid` = 0; `rdata`, `rresp`, `rid`, `bresp`, `bid` = 0.
- `mtime` counting:
  - The divider counts 0..TICK_DIV-1; on wrap, `mtime` increments by 1.
  - `mtime` is 64-bit and wraps from all-ones to 0.
  - A write to either `mtime` word takes priority over the increment in that cycle: the written bytes are loaded, that cycle's increment is lost, and the divider is not reset.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: `arready` = 1. On `arvalid && arready`, the edge latches the register value, `resp` and `id` into `rdata`/`rresp`/`rid`, then moves to R_RESP with `rvalid` = 1 and `arready` = 0.
  - AR-to-R latency is exactly 1 cycle.
  - R_RESP: `rdata`/`rresp`/`rid` are held stable until `rvalid && rready`. The next state is R_IDLE, so `arready` reasserts the cycle after the R handshake; back-to-back reads therefore take 2 cycles minimum.
- Write FSM: AW and W are accepted independently, in either order or in the same cycle.
  - On AW handshake: latch `addr`/`id` and drop `awready`.
  - On W handshake: latch `data`/`strb` and drop `wready`.
  - At the edge where the second of the two is accepted (or both together): commit the byte-strobed write using the live-or-latched values, set `bvalid` = 1, and load `bresp`/`bid`.
  - `bvalid` is held until `bready`.
  - At the B handshake edge, `awready` and `wready` both return to 1.
  - `wstrb` = 0000 writes nothing but still returns OKAY.
- Read and write in the same cycle:
  - Both channels proceed concurrently.
  - A read latched on the same edge as a write commit returns the pre-write value.
- `timer_irq`:
  - Registered; it reflects the comparison of the current `mtime` and `mtimecmp`, so it lags a register update by 1 cycle.
  - It is level-sensitive and is cleared only by raising `mtimecmp` or lowering `mtime`.
- Reset asserted mid-transaction: all in-flight AR/AW/W state is discarded. The cycle after the reset edge shows reset values on every output, and no partial write is committed.

Test Plan:
1. Reset, then read 0xBFF8 at cycle 10 with TICK_DIV=1 → `rvalid` 1 cycle after AR, `rresp`=00, `rlast`=1, `rdata` equal to the cycle count at the AR handshake (±0 relative to the bench model). Read 0x4004 → 32'hFFFF_FFFF. `timer_irq`=0.
2. Write 0x4000 with 32'd50 and 0x4004 with 32'd0, `wstrb`=1111, AW and W in the same cycle → `bvalid` the next cycle, `bresp`=00, `bid` echoes `awid`=4'h3. `timer_irq` rises exactly 1 cycle after `mtime` reaches 50.
3. W presented 3 cycles before AW with `wstrb`=0010 and `wdata`=32'h0000_AB00 to 0xBFF8 while `mtime`=0x1234 → after commit `mtime[15:8]`=8'hAB, other bytes unchanged, and no increment on the commit cycle.
4. Read 0x0000 → `rresp`=10, `rdata`=0. Read 0x1000_0000 → `rresp`=11. Write to 0x0010 → `bresp`=10 with registers unchanged.
5. Hold `rready`=0 for 5 cycles → `rvalid`, `rdata` and `rid` stay constant and `arready` stays 0. `arready`=1 the cycle after `rready` rises.
6. Assert reset while AW is accepted but W is pending → the next cycle shows `awready`=`wready`=1 and `bvalid`=0; a subsequent full write completes normally.
